// File: rtl/aux_uart_hub_pkg.sv
// Shared constants for the aux-bus UART hub: register offsets, STAT bit layout, channel stride.
package aux_uart_hub_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_PREL = 2'd2;
    localparam logic [1:0] REG_PREH = 2'd3;

    localparam int STAT_RXNE    = 0;
    localparam int STAT_TXFULL  = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_TXEMPTY = 3;
    localparam int STAT_IE      = 7;

    localparam int CH_STRIDE = 4;

    function automatic logic [7:0] stat_byte(logic ie, logic tx_empty, logic ovf,
                                             logic tx_full, logic rx_ne);
        logic [7:0] s;
        s = '0;
        s[STAT_IE]      = ie;
        s[STAT_TXEMPTY] = tx_empty;
        s[STAT_OVF]     = ovf;
        s[STAT_TXFULL]  = tx_full;
        s[STAT_RXNE]    = rx_ne;
        return s;
    endfunction

endpackage

// File: rtl/aux_uart_hub_if.sv
// risc16f84 aux bus as seen by a peripheral; the core is the master.
interface aux_uart_hub_if;
    logic [15:0] aux_adr_i;
    logic [7:0]  aux_dat_i;
    logic [7:0]  aux_dat_o;
    logic        aux_dat_oe;
    logic        aux_we_i;
    logic        aux_re_i;

    modport master (output aux_adr_i, aux_dat_i, aux_we_i, aux_re_i,
                    input  aux_dat_o, aux_dat_oe);
    modport slave  (input  aux_adr_i, aux_dat_i, aux_we_i, aux_re_i,
                    output aux_dat_o, aux_dat_oe);
endinterface

// File: rtl/aux_uart_hub_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; pushes at full and pops at empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/aux_uart_hub.sv
// Multi-channel UART register front-end on the aux bus: per-channel TX/RX FIFOs,
// prescale and sticky status, bridged to external uart cores over AXI-stream.
module aux_uart_hub
    import aux_uart_hub_pkg::*;
#(
    parameter int          NUM_CH     = 2,
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] PRESC_RST  = 16'd54
) (
    input  logic                     clk,
    input  logic                     reset_n,
    aux_uart_hub_if.slave            aux,
    output logic                     irq_o,
    output logic [NUM_CH-1:0][7:0]   tx_tdata_o,
    output logic [NUM_CH-1:0]        tx_tvalid_o,
    input  logic [NUM_CH-1:0]        tx_tready_i,
    input  logic [NUM_CH-1:0][7:0]   rx_tdata_i,
    input  logic [NUM_CH-1:0]        rx_tvalid_i,
    output logic [NUM_CH-1:0]        rx_tready_o,
    output logic [NUM_CH-1:0][15:0]  prescale_o
);
    localparam int CH_LSB = $clog2(CH_STRIDE);

    logic [15:0] rel;
    logic        hit;
    logic [2:0]  ch_idx;
    logic [1:0]  off;
    logic        we_q, re_q, we_p, re_p;

    logic [NUM_CH-1:0]       sel, tx_full, tx_empty, rx_full, rx_empty, ie_v, ovf_v;
    logic [NUM_CH-1:0][7:0]  rx_head;
    logic [7:0]              rd;

    // Window is 32-byte aligned, so everything above bit 4 of the offset must be zero.
    assign rel    = aux.aux_adr_i - BASE_ADDR;
    assign hit    = (rel[15:CH_LSB+3] == '0);
    assign ch_idx = rel[CH_LSB+:3];
    assign off    = rel[CH_LSB-1:0];

    // Act only on the first cycle of a strobe; a concurrent write suppresses the pop.
    assign we_p = aux.aux_we_i & ~we_q & hit;
    assign re_p = aux.aux_re_i & ~re_q & ~aux.aux_we_i & hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q  <= 1'b0;
            re_q  <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            we_q  <= aux.aux_we_i;
            re_q  <= aux.aux_re_i;
            irq_o <= |(ie_v & (~rx_empty | ovf_v));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic        ie, ovf;
        logic [15:0] presc;
        logic        wr_stat;

        assign sel[c]  = (ch_idx == 3'(c));
        assign wr_stat = we_p & sel[c] & (off == REG_STAT);

        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (we_p & sel[c] & (off == REG_DATA)),
            .din     (aux.aux_dat_i),
            .pop     (tx_tvalid_o[c] & tx_tready_i[c]),
            .full    (tx_full[c]),
            .empty   (tx_empty[c]),
            .head    (tx_tdata_o[c])
        );

        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (rx_tvalid_i[c]),
            .din     (rx_tdata_i[c]),
            .pop     (re_p & sel[c] & (off == REG_DATA)),
            .full    (rx_full[c]),
            .empty   (rx_empty[c]),
            .head    (rx_head[c])
        );

        assign tx_tvalid_o[c] = ~tx_empty[c];
        assign rx_tready_o[c] = ~rx_full[c];

        // A lost beat in the same cycle as the W1C keeps OVF set.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ie    <= 1'b0;
                ovf   <= 1'b0;
                presc <= PRESC_RST;
            end else begin
                if (rx_tvalid_i[c] & rx_full[c])           ovf <= 1'b1;
                else if (wr_stat & aux.aux_dat_i[STAT_OVF]) ovf <= 1'b0;
                if (wr_stat) ie <= aux.aux_dat_i[STAT_IE];
                if (we_p & sel[c] & (off == REG_PREL)) presc[7:0]  <= aux.aux_dat_i;
                if (we_p & sel[c] & (off == REG_PREH)) presc[15:8] <= aux.aux_dat_i;
            end
        end

        assign ie_v[c]       = ie;
        assign ovf_v[c]      = ovf;
        assign prescale_o[c] = presc;
    end

    always_comb begin
        rd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == c[2:0]) begin
                case (off)
                    REG_DATA: rd = rx_empty[c] ? 8'h00 : rx_head[c];
                    REG_STAT: rd = stat_byte(ie_v[c], tx_empty[c], ovf_v[c], tx_full[c], ~rx_empty[c]);
                    REG_PREL: rd = prescale_o[c][7:0];
                    default:  rd = prescale_o[c][15:8];
                endcase
            end
        end
    end

    assign aux.aux_dat_oe = aux.aux_re_i & hit;
    assign aux.aux_dat_o  = aux.aux_dat_oe ? rd : 8'h00;

endmodule
